// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through D$ subsystem.
package wt_cache_pkg;

  // Widest address any helper in this package handles.
  localparam int unsigned MaxAddrW = 64;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    EXPAND = 1'b1
  } inval_gen_state_e;

  // Clear the byte-in-line bits of an address; line_bytes must be a power of two.
  function automatic logic [MaxAddrW-1:0] line_align(input logic [MaxAddrW-1:0] addr,
                                                     input int unsigned         line_bytes);
    logic [MaxAddrW-1:0] mask;
    mask = ~(MaxAddrW'(line_bytes) - MaxAddrW'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with occupancy output. A push into a full FIFO is
// accepted when a pop happens in the same cycle, so occupancy passes through.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned ADDR_DEPTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   count_q;
  logic                  bypass, do_wr, do_rd;

  // In fall-through mode an empty FIFO forwards a simultaneous push straight to the pop.
  assign bypass  = FALL_THROUGH && (count_q == '0) && push_i && pop_i;
  assign full_o  = (count_q == (ADDR_DEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0) && !(FALL_THROUGH && push_i);
  assign usage_o = count_q[ADDR_DEPTH-1:0];
  assign data_o  = (FALL_THROUGH && count_q == '0) ? data_i : mem_q[rd_ptr_q];

  assign do_wr = push_i && (!full_o || pop_i) && !bypass;
  assign do_rd = pop_i && !empty_o && !bypass;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= (wr_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= (rd_ptr_q == ADDR_DEPTH'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (do_wr && !do_rd)      count_q <= count_q + 1'b1;
      else if (do_rd && !do_wr) count_q <= count_q - 1'b1;
    end
  end

  // Storage; contents are only meaningful where the pointers say so.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/wt_inval_gen.sv
// Snoops foreign write bursts, expands them into line-aligned D$
// invalidations, drops back-to-back repeats of the same line, and hands
// them to the cache through a small FIFO with valid/ready flow control.
module wt_inval_gen
  import wt_cache_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineBytes = 16,
  parameter int unsigned FifoDepth = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 snoop_valid_i,
  output logic                 snoop_ready_o,
  input  logic [AddrWidth-1:0] snoop_addr_i,
  input  logic [7:0]           snoop_len_i,
  input  logic [2:0]           snoop_size_i,
  output logic [63:0]          inval_addr_o,
  output logic                 inval_valid_o,
  input  logic                 inval_ready_i,
  output logic                 busy_o,
  output logic [31:0]          inval_cnt_o
);

  localparam int unsigned LineOffW = $clog2(LineBytes);
  localparam int unsigned UsageW   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  inval_gen_state_e     state_q;
  logic                 snoop_ready_q;
  logic [12:0]          remaining_q;
  logic [AddrWidth-1:0] cur_q;
  logic [AddrWidth-1:0] last_line_q;
  logic                 last_vld_q;
  logic [31:0]          cnt_q;

  logic [15:0]          span;
  logic [AddrWidth-1:0] start_line, end_line;
  logic [12:0]          lines;
  logic                 accept, in_expand, suppress, pop, push, advance, drains;
  logic                 fifo_full, fifo_empty;
  logic [UsageW-1:0]    fifo_usage;
  logic [AddrWidth-1:0] fifo_head;

  // Burst geometry: bytes touched, first and last line, and line count.
  assign span       = (16'(snoop_len_i) + 16'd1) << snoop_size_i;
  assign start_line = AddrWidth'(line_align(MaxAddrW'(snoop_addr_i), LineBytes));
  assign end_line   = AddrWidth'(line_align(MaxAddrW'(snoop_addr_i + AddrWidth'(span)
                                                      - AddrWidth'(1)), LineBytes));
  assign lines      = 13'((end_line - start_line) >> LineOffW) + 13'd1;

  assign accept    = (state_q == IDLE) && snoop_valid_i && enable_i;
  assign in_expand = (state_q == EXPAND);
  assign pop       = !fifo_empty && inval_ready_i;
  // A line equal to the newest queued one is already covered.
  assign suppress  = in_expand && last_vld_q && (cur_q == last_line_q);
  assign push      = in_expand && !suppress && (!fifo_full || pop);
  assign advance   = suppress || push;
  // The last queued entry leaves with nothing replacing it.
  assign drains    = pop && !fifo_full && (fifo_usage == UsageW'(1)) && !push;

  // Expander control: accept a burst in IDLE, walk its lines in EXPAND.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      snoop_ready_q <= 1'b1;
      remaining_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            remaining_q   <= lines;
            state_q       <= EXPAND;
            snoop_ready_q <= 1'b0;
          end
        end
        EXPAND: begin
          if (advance) begin
            remaining_q <= remaining_q - 13'd1;
            if (remaining_q == 13'd1) begin
              state_q       <= IDLE;
              snoop_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q       <= IDLE;
          snoop_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Current candidate line; held while the FIFO back-pressures.
  always_ff @(posedge clk_i) begin
    if (accept)       cur_q <= start_line;
    else if (advance) cur_q <= cur_q + AddrWidth'(LineBytes);
  end

  // Dedup flag: armed by every push, dropped once the FIFO runs empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_vld_q <= 1'b0;
    else if (push)   last_vld_q <= 1'b1;
    else if (drains) last_vld_q <= 1'b0;
  end

  // Most recently queued line, qualified by last_vld_q.
  always_ff @(posedge clk_i) begin
    if (push) last_line_q <= cur_q;
  end

  // Issued-invalidation counter, wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)    cnt_q <= '0;
    else if (pop) cnt_q <= cnt_q + 32'd1;
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (AddrWidth),
    .DEPTH        (FifoDepth)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (cur_q),
    .push_i  (push),
    .data_o  (fifo_head),
    .pop_i   (pop)
  );

  assign snoop_ready_o = snoop_ready_q;
  assign inval_valid_o = !fifo_empty;
  // Storage is not reset, so present zero whenever nothing is queued.
  assign inval_addr_o  = fifo_empty ? 64'd0 : 64'(fifo_head);
  assign busy_o        = in_expand | !fifo_empty;
  assign inval_cnt_o   = cnt_q;

endmodule

// File: tb/tb_wt_inval_gen.sv
// Directed and randomized bench for wt_inval_gen with a line-list scoreboard.
module tb_wt_inval_gen;

  localparam int unsigned LB = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        snoop_valid_i;
  logic        snoop_ready_o;
  logic [63:0] snoop_addr_i;
  logic [7:0]  snoop_len_i;
  logic [2:0]  snoop_size_i;
  logic [63:0] inval_addr_o;
  logic        inval_valid_o;
  logic        inval_ready_i;
  logic        busy_o;
  logic [31:0] inval_cnt_o;

  int          passed = 0;
  int          total  = 0;
  logic [63:0] got[$];
  logic [63:0] exp_q[$];
  bit          sends_done;
  logic [31:0] cnt_before;

  wt_inval_gen #(.AddrWidth(64), .LineBytes(LB), .FifoDepth(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .snoop_valid_i (snoop_valid_i),
    .snoop_ready_o (snoop_ready_o),
    .snoop_addr_i  (snoop_addr_i),
    .snoop_len_i   (snoop_len_i),
    .snoop_size_i  (snoop_size_i),
    .inval_addr_o  (inval_addr_o),
    .inval_valid_o (inval_valid_o),
    .inval_ready_i (inval_ready_i),
    .busy_o        (busy_o),
    .inval_cnt_o   (inval_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Record every accepted invalidation; inputs only change just after posedge.
  always @(negedge clk_i) begin
    if (!rst_i && inval_valid_o && inval_ready_i) got.push_back(inval_addr_o);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one snoop beat and hold it until the DUT takes it.
  task automatic send(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    bit ok;
    ok = 1'b0;
    snoop_addr_i  = a;
    snoop_len_i   = l;
    snoop_size_i  = s;
    snoop_valid_i = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (snoop_ready_o) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    snoop_valid_i = 1'b0;
    check("snoop_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_got(input int n);
    for (int c = 0; c < 200; c++) begin
      if (got.size() >= n) break;
      tick();
    end
  endtask

  // Reference: every line the burst touches, lowest first.
  task automatic model_burst(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s);
    logic [63:0] bytes, first, last;
    bytes = (64'(l) + 64'd1) << s;
    first = (a / LB) * LB;
    last  = ((a + bytes - 64'd1) / LB) * LB;
    for (logic [63:0] x = first; x <= last; x += LB) exp_q.push_back(x);
  endtask

  initial begin
    rst_i = 1'b1; enable_i = 1'b1; snoop_valid_i = 1'b0; inval_ready_i = 1'b0;
    snoop_addr_i = '0; snoop_len_i = '0; snoop_size_i = '0; sends_done = 1'b0;
    tick(); tick();
    check("rst_snoop_ready", 64'(snoop_ready_o), 64'd1);
    check("rst_inval_valid", 64'(inval_valid_o), 64'd0);
    check("rst_inval_addr", inval_addr_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_cnt", 64'(inval_cnt_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Single beat, one line
    inval_ready_i = 1'b1;
    send(64'h1008, 8'd0, 3'd3);
    check("t1_no_valid_yet", 64'(inval_valid_o), 64'd0);
    check("t1_ready_low", 64'(snoop_ready_o), 64'd0);
    tick();
    check("t1_valid", 64'(inval_valid_o), 64'd1);
    check("t1_addr", inval_addr_o, 64'h1000);
    check("t1_ready_back", 64'(snoop_ready_o), 64'd1);
    tick();
    check("t1_idle", 64'(inval_valid_o), 64'd0);
    check("t1_cnt", 64'(inval_cnt_o), 64'd1);

    // Unaligned burst spanning three lines
    send(64'h2004, 8'd7, 3'd2);
    tick();
    check("t2_l0", inval_addr_o, 64'h2000);
    tick();
    check("t2_l1", inval_addr_o, 64'h2010);
    tick();
    check("t2_l2", inval_addr_o, 64'h2020);
    tick();
    check("t2_done", 64'(inval_valid_o), 64'd0);
    check("t2_cnt", 64'(inval_cnt_o), 64'd4);

    // Backpressure: 8 lines into a 4-deep FIFO
    inval_ready_i = 1'b0;
    got.delete();
    send(64'h5000, 8'd7, 3'd4);
    repeat (6) tick();
    check("t3_valid", 64'(inval_valid_o), 64'd1);
    check("t3_head", inval_addr_o, 64'h5000);
    check("t3_snoop_stall", 64'(snoop_ready_o), 64'd0);
    check("t3_busy", 64'(busy_o), 64'd1);
    check("t3_cnt_hold", 64'(inval_cnt_o), 64'd4);
    inval_ready_i = 1'b1;
    wait_got(8);
    repeat (2) tick();
    check("t3_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      check("t3_line", got[i], 64'h5000 + 64'(i) * LB);
    check("t3_busy_done", 64'(busy_o), 64'd0);
    check("t3_snoop_ready", 64'(snoop_ready_o), 64'd1);
    check("t3_cnt", 64'(inval_cnt_o), 64'd12);

    // Dedup of a repeated line while the first is pending
    inval_ready_i = 1'b0;
    got.delete();
    send(64'h3000, 8'd0, 3'd3);
    send(64'h3008, 8'd0, 3'd3);
    repeat (3) tick();
    check("t4_head", inval_addr_o, 64'h3000);
    inval_ready_i = 1'b1;
    wait_got(1);
    repeat (3) tick();
    check("t4_one_issue", 64'(got.size()), 64'd1);
    if (got.size() > 0) check("t4_addr", got[0], 64'h3000);
    check("t4_empty", 64'(inval_valid_o), 64'd0);
    check("t4_cnt", 64'(inval_cnt_o), 64'd13);
    send(64'h3000, 8'd0, 3'd3);
    wait_got(2);
    repeat (2) tick();
    check("t4_reissue_count", 64'(got.size()), 64'd2);
    if (got.size() > 1) check("t4_reissue_addr", got[1], 64'h3000);
    check("t4_cnt2", 64'(inval_cnt_o), 64'd14);

    // Disabled: beat accepted and dropped
    enable_i = 1'b0;
    snoop_addr_i = 64'h4000; snoop_len_i = 8'd0; snoop_size_i = 3'd3;
    snoop_valid_i = 1'b1;
    check("t5_ready", 64'(snoop_ready_o), 64'd1);
    tick(); tick();
    snoop_valid_i = 1'b0;
    check("t5_no_valid", 64'(inval_valid_o), 64'd0);
    check("t5_not_busy", 64'(busy_o), 64'd0);
    check("t5_cnt", 64'(inval_cnt_o), 64'd14);
    check("t5_ready_after", 64'(snoop_ready_o), 64'd1);
    enable_i = 1'b1;

    // Reset in the middle of a burst
    inval_ready_i = 1'b0;
    send(64'h6000, 8'd7, 3'd4);
    tick(); tick();
    check("t6_pre_valid", 64'(inval_valid_o), 64'd1);
    check("t6_pre_busy", 64'(busy_o), 64'd1);
    rst_i = 1'b1;
    tick();
    check("t6_valid", 64'(inval_valid_o), 64'd0);
    check("t6_busy", 64'(busy_o), 64'd0);
    check("t6_snoop_ready", 64'(snoop_ready_o), 64'd1);
    check("t6_cnt", 64'(inval_cnt_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Random bursts on distinct 4KB pages under random backpressure
    got.delete();
    exp_q.delete();
    cnt_before = inval_cnt_o;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          logic [63:0] a;
          logic [7:0]  l;
          logic [2:0]  s;
          a = 64'h10000 + 64'(k) * 64'h1000 + 64'($urandom_range(0, 32'hE00));
          l = 8'($urandom_range(0, 15));
          s = 3'($urandom_range(0, 3));
          model_burst(a, l, s);
          send(a, l, s);
        end
        sends_done = 1'b1;
      end
      begin
        for (int c = 0; c < 5000; c++) begin
          if (sends_done && got.size() >= exp_q.size()) break;
          inval_ready_i = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    inval_ready_i = 1'b1;
    repeat (3) tick();
    check("rnd_count", 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      check("rnd_line", got[i], exp_q[i]);
    check("rnd_cnt", 64'(inval_cnt_o - cnt_before), 64'(exp_q.size()));
    check("rnd_idle", 64'(busy_o), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/wt_inval_gen.md
Name: wt_inval_gen

Overview:
- Source end of the D$ invalidation handshake (inval_addr/inval_valid/inval_ready) consumed by the write-through cache subsystem.
- Snoops write-address traffic from other bus masters (DMA, peer cores), expands each write burst into line-aligned invalidation requests and buffers them.
- Issues the requests towards the cache with valid/ready flow control.
- Sits between the system interconnect snoop tap and the cache subsystem's invalidation input.

Parameters:
AddrWidth, 64, snoop and invalidation address width
LineBytes, 16, D$ line size in bytes; power of two, >=8; must equal DCACHE_LINE_WIDTH/8
FifoDepth, 4, pending invalidation entries; power of two, >=2

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  1: generate invalidations; 0: accept and discard snoops
snoop_valid_i  in  1  write-address beat valid
snoop_ready_o  out  1  write-address beat accepted
snoop_addr_i  in  AddrWidth  AXI AWADDR
snoop_len_i  in  8  AXI AWLEN (beats-1)
snoop_size_i  in  3  AXI AWSIZE (bytes per beat = 1<<size)
inval_addr_o  out  64  line-aligned physical address to invalidate
inval_valid_o  out  1  invalidation request valid
inval_ready_i  in  1  cache accepted invalidation
busy_o  out  1  expander active or FIFO non-empty
inval_cnt_o  out  32  invalidations issued (valid&&ready), wraps at 2^32

Behaviour:
- Clock and reset: one clock clk_i; asynchronous active-high reset rst_i.
- Reset values: snoop_ready_o=1, inval_valid_o=0, inval_addr_o=0, busy_o=0, inval_cnt_o=0. FSM returns to IDLE, FIFO empty, dedup flag clear.
- Mid-operation reset: in-flight expansion and FIFO contents are discarded.
- Definitions (LO=log2(LineBytes)):
  - span=(len+1)<<size, 16-bit.
  - start_line = addr & ~(LineBytes-1).
  - end_line = (addr+span-1) & ~(LineBytes-1), modulo 2^AddrWidth.
  - lines = ((end_line-start_line)>>LO)+1, 13 bits, modulo wrap.
  - AXI forbids 4KB crossing, so lines<=4096/LineBytes; other values are not checked.
- FSM IDLE:
  - snoop_ready_o=1.
  - On snoop_valid_i && enable_i: latch cur=start_line and remaining=lines, go to EXPAND.
  - If enable_i=0, the beat is accepted and dropped; stay in IDLE.
- FSM EXPAND:
  - snoop_ready_o=0.
  - Each cycle, candidate=cur.
  - If the FIFO is not full (or a pop happens the same cycle), or the candidate is suppressed: advance cur+=LineBytes, remaining-=1.
  - Push the candidate unless suppressed.
  - When remaining reaches 1 and the candidate is consumed, return to IDLE. The next snoop is accepted no earlier than the following cycle.
  - Throughput: 1 line/cycle absent backpressure.
- Dedup:
  - last_line register, last_vld flag.
  - Suppress the candidate if last_vld && candidate==last_line.
  - Set last_vld/last_line on every push.
  - Clear last_vld when the FIFO becomes empty (pop with occupancy 1 and no push that cycle).
- FIFO full: the expander stalls, holding cur/remaining. snoop_ready_o stays 0.
- Simultaneous push+pop on a full FIFO is allowed (pass-through of occupancy); no entry is lost.
- Output:
  - inval_valid_o = FIFO non-empty; inval_addr_o = FIFO head, zero-extended to 64 bits.
  - Head is stable while valid && !ready.
  - Pop on valid && ready; inval_cnt_o increments the same edge.
- enable_i falling mid-EXPAND: the current burst completes. FIFO contents still drain.
- busy_o = (state==EXPAND) | FIFO non-empty.

Decomposition:
- Shared package wt_cache_pkg holds:
  - inval_gen_state_e {IDLE, EXPAND};
  - function line_align(addr, LineBytes).
- Buffer is the common_cells fifo_v3 (FALL_THROUGH=0, DEPTH=FifoDepth, DATA_WIDTH=AddrWidth), clocked with rst_ni=~rst_i.
- Expander FSM, dedup and counter stay in this module.

Test Plan:
- Single write addr=0x1008, len=0, size=3, ready_i=1 -> one invalidation 0x1000, one cycle after the FSM enters EXPAND; inval_cnt_o=1.
- Burst addr=0x2004, len=7, size=2 (span 32, end 0x2023) -> invalidations 0x2000, 0x2010, 0x2020 in consecutive cycles.
- ready_i=0, burst of 8 lines, FifoDepth=4 -> 4 entries buffered, snoop_ready_o=0, expander stalls. Then raise ready_i -> all 8 lines emitted in order, none duplicated or lost.
- Back-to-back writes to 0x3000 and 0x3008 while the first entry is pending -> one invalidation 0x3000. Repeat after the FIFO drains -> a second 0x3000 is issued.
- enable_i=0, snoop at 0x4000 -> snoop_ready_o=1, no inval_valid_o, inval_cnt_o unchanged.
- Assert rst_i mid-burst with 2 FIFO entries -> next cycle inval_valid_o=0, busy_o=0, snoop_ready_o=1, inval_cnt_o=0.
